fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RV32I core, sitting directly upstream of instruction decode and the R/I/L/S/B execution units. Owns the program counter, issues word reads to instruction memory over a request/grant/response handshake, buffers returned instructions with their PCs in a small FIFO, and presents them to decode over a valid/ready handshake. Accepts redirects from the branch unit's next-PC result, flushing stale work.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2

- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- redirect_valid  in  1  branch/jump taken; load new PC this cycle
- redirect_pc  in  32  redirect target (branch unit next-PC value)
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch word address (equals fetch PC)
- imem_gnt  in  1  request accepted when imem_req && imem_gnt
- imem_rvalid  in  1  read data valid for oldest accepted request
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr_data/instr_pc valid to decode
- instr_ready  in  1  decode consumes entry when instr_valid && instr_ready
- instr_data  out  32  instruction word (idata to decode)
- instr_pc  out  32  PC of instr_data (iaddr to branch unit)
- misalign  out  1  only with FETCH_ALIGN_CHECK_EN; sticky misaligned-redirect flag

## Operation
- Fetch PC register fpc; imem_addr = fpc. fpc advances by 4 on each accepted request; 32'hFFFF_FFFC wraps to 0.
- At most one outstanding request. imem_req asserted only when no request outstanding and (FIFO count) < FIFO_DEPTH.
- FSM: RUN (may request), WAIT (one outstanding, result kept), DISCARD (one outstanding, result dropped).
  - RUN → WAIT on accepted request.
  - WAIT → RUN on imem_rvalid; data + its PC pushed into FIFO.
  - WAIT → DISCARD on redirect_valid without imem_rvalid the same cycle.
  - DISCARD → RUN on imem_rvalid; data dropped.
- Redirect (any state): FIFO flushed, fpc ← redirect_pc, instr_valid low next cycle. Redirect beats a same-cycle pop, push, and rvalid (response dropped). A redirect in the same cycle as an accept: the accepted request's response is discarded (go to DISCARD).
- imem_addr may change while imem_req high and not granted only due to redirect.
- FIFO: push on kept rvalid, pop on instr_valid && instr_ready; simultaneous push and pop when full is impossible by issue rule; pushes when empty with a same-cycle pop not bypassed.

## Timing
- Reset (rst_n low at edge): fpc=RESET_PC, FSM=RUN, FIFO empty, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, misalign=0. imem_req rises the first cycle rst_n is high.
- Reset mid-request: outstanding request forgotten; late imem_rvalid after reset ignored (FSM in RUN, no request outstanding).
- Latency: accept in cycle N, rvalid earliest N+1, instr_valid earliest N+2.
- Back-to-back zero-wait memory: one instruction per 2 cycles sustained.
- Redirect in cycle N: imem_addr = redirect_pc in N+1; instr_valid=0 in N+1.
- Outputs registered; no combinational path from instr_ready or imem_gnt to imem_req.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]≠0 sets misalign (sticky until reset), flushes as normal, and stops all further requests (imem_req held 0); the fetch unit halts.
- Undefined: no misalign port; redirect_pc[1:0] forced to 0 on load.

## Structure
- Shared package (rv32i_pkg): XLEN=32, PC_STEP=4, fetch state enum type (RUN/WAIT/DISCARD), RESET_PC default constant.
- One sub-module: fetch_fifo (parameterised DEPTH × 64-bit {pc,instr}, push/pop/flush, count, full/empty).

## Test plan
- Reset release, memory grants every cycle, rvalid next cycle, imem_rdata=32'h0000_0013 → first instr_valid with instr_pc=0, next fetch at addr 4, instr_pc sequence 0,4,8.
- instr_ready held 0 → after 2 instructions FIFO full, imem_req stays 0; ready=1 one cycle → one pop, one new request issued.
- Request to 0x8 accepted, redirect_pc=0x100 next cycle before rvalid → 0x8 response dropped, next instr_pc=0x100.
- redirect_valid, imem_rvalid and instr_ready same cycle with FIFO non-empty → FIFO empty, no push, imem_addr=redirect_pc next cycle.
- redirect_pc=0xFFFF_FFFC → following fetches 0xFFFF_FFFC then 0x0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect_pc=0x102 → misalign=1 next cycle, imem_req=0 thereafter until reset.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: datapath width, PC step, reset PC and the
// fetch-stage request state type.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP      = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  // RUN may issue; WAIT keeps the outstanding response; DISCARD drops it
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small {pc,instr} buffer between fetch and decode. DEPTH must be a power of
// two. Flush empties it in one cycle. The head reads as zero when empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [W-1:0]             o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the count alone
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  assign o_dout = o_empty ? '0 : r_mem[r_rd];

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, keeps one imem request in flight and
// buffers results for decode. FETCH_ALIGN_CHECK_EN adds a sticky misalign halt.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            misalign
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] w_redir_pc;
  logic            r_live;
  logic            w_halt;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [CNT_W-1:0] w_count;
  logic [2*XLEN-1:0] w_head;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_misalign <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
      r_misalign <= 1'b1;
  end

  assign misalign   = r_misalign;
  assign w_halt     = r_misalign;
  assign w_redir_pc = redirect_pc;
`else
  assign w_halt     = 1'b0;
  assign w_redir_pc = redirect_pc & ~32'h0000_0003;
`endif

  // Request depends on registered state only; r_live keeps it low through reset
  assign imem_req  = r_live && !w_halt && (r_state == ST_RUN) &&
                     (w_count < CNT_W'(FIFO_DEPTH));
  assign imem_addr = r_fpc;
  assign w_accept  = imem_req && imem_gnt;
  assign w_push    = (r_state == ST_WAIT) && imem_rvalid && !redirect_valid && !w_full;
  assign w_pop     = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:
        if (w_accept) w_state_nxt = redirect_valid ? ST_DISCARD : ST_WAIT;
      ST_WAIT:
        if (imem_rvalid)         w_state_nxt = ST_RUN;
        else if (redirect_valid) w_state_nxt = ST_DISCARD;
      ST_DISCARD:
        if (imem_rvalid) w_state_nxt = ST_RUN;
      default:
        w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_fpc   <= RESET_PC;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (redirect_valid)
        r_fpc <= w_redir_pc;
      else if (w_accept)
        r_fpc <= r_fpc + PC_STEP;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2*XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   ({r_fpc - PC_STEP, imem_rdata}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign instr_valid = !w_empty;
  assign instr_pc    = w_head[2*XLEN-1:XLEN];
  assign instr_data  = w_head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign;
`endif

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding requests and buffered instructions as queues
  typedef struct packed { logic [31:0] a; logic k; } req_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] d; } ent_t;
  req_t        outq[$];
  ent_t        fq[$];
  logic [31:0] m_fpc = 32'h0;
  bit          m_live = 0;
  bit          m_mis = 0;
  bit          chk_en = 0;

  function automatic bit m_req();
    return m_live && !m_mis && (outq.size() == 0) && (fq.size() < DEPTH);
  endfunction

  always @(posedge clk) begin
    bit   acc, rv, keep, pop;
    req_t e, r;
    ent_t n;
    if (!rst_n) begin
      outq.delete(); fq.delete();
      m_fpc = 32'h0; m_live = 0; m_mis = 0; chk_en = 1;
    end else begin
      acc  = m_req() && imem_gnt;
      rv   = imem_rvalid && (outq.size() > 0);
      keep = 0;
      e    = '0;
      if (rv) begin
        e = outq.pop_front();
        keep = e.k && !redirect_valid;
      end
      pop = (fq.size() > 0) && instr_ready;
      if (redirect_valid) begin
        fq.delete();
        foreach (outq[i]) outq[i].k = 1'b0;
      end else begin
        if (pop) void'(fq.pop_front());
        if (keep) begin n.pc = e.a; n.d = imem_rdata; fq.push_back(n); end
      end
      if (acc) begin r.a = m_fpc; r.k = !redirect_valid; outq.push_back(r); end
      if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) m_mis = 1;
        m_fpc = redirect_pc;
`else
        m_fpc = {redirect_pc[31:2], 2'b00};
`endif
      end else if (acc) begin
        m_fpc = m_fpc + 32'd4;
      end
      m_live = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_req", imem_req, m_req());
      chk("model_addr", imem_addr, m_fpc);
      chk("model_valid", instr_valid, fq.size() > 0);
      if (fq.size() > 0) begin
        chk("model_pc", instr_pc, fq[0].pc);
        chk("model_data", instr_data, fq[0].d);
      end
`ifdef FETCH_ALIGN_CHECK_EN
      chk("model_misalign", misalign, m_mis);
`endif
    end
  end

  // Memory responder: one-cycle latency, rdata = addr + 0x13, optional hold
  bit          pend = 0;
  bit          rv_hold = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] acc_q[$];

  task automatic step(input bit gnt, input bit rdy, input bit rdr, input logic [31:0] rpc);
    @(negedge clk);
    if (pend && !rv_hold) begin
      imem_rvalid = 1'b1; imem_rdata = pend_addr + 32'h13; pend = 0;
    end else begin
      imem_rvalid = 1'b0; imem_rdata = '0;
    end
    imem_gnt = gnt; instr_ready = rdy; redirect_valid = rdr; redirect_pc = rpc;
    if (imem_req && gnt && rst_n) begin
      pend = 1; pend_addr = imem_addr; acc_q.push_back(imem_addr);
    end
  endtask

  task automatic do_reset(input bit rdy);
    rst_n = 1'b0; pend = 0; rv_hold = 0;
    repeat (2) step(1'b0, rdy, 1'b0, 32'h0);
    acc_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string nm, input bit rdy);
    for (int i = 0; i < 20 && !instr_valid; i++) step(1'b1, rdy, 1'b0, 32'h0);
    chk(nm, instr_valid, 1'b1);
  endtask

  task automatic wait_addr(input string nm, input bit rdy, input logic [31:0] a);
    for (int i = 0; i < 20 && !(imem_req && imem_addr == a); i++) step(1'b1, rdy, 1'b0, 32'h0);
    chk(nm, imem_req && (imem_addr == a), 1'b1);
  endtask

  initial begin
    // Reset state and basic in-order fetch with a zero-wait memory
    do_reset(1'b1);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_data", instr_data, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rel_req", imem_req, 1'b1);
    chk("rel_addr", imem_addr, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wait_req", imem_req, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("first_valid", instr_valid, 1'b1);
    chk("first_pc", instr_pc, 32'h0);
    chk("first_data", instr_data, 32'h0000_0013);
    chk("next_addr", imem_addr, 32'h4);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("gap_valid", instr_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("second_pc", instr_pc, 32'h4);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("third_pc", instr_pc, 32'h8);
    chk("third_data", instr_data, 32'h0000_001B);
    chk("acc_count", acc_q.size() >= 3, 1'b1);
    if (acc_q.size() >= 3) begin
      chk("acc0", acc_q[0], 32'h0);
      chk("acc1", acc_q[1], 32'h4);
      chk("acc2", acc_q[2], 32'h8);
    end

    // Backpressure: buffer fills, requests stop, one pop frees one request
    do_reset(1'b0);
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_valid", instr_valid, 1'b1);
    chk("full_pc", instr_pc, 32'h0);
    chk("full_req", imem_req, 1'b0);
    chk("full_addr", imem_addr, 32'h8);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("pop_pc", instr_pc, 32'h4);
    chk("pop_req", imem_req, 1'b1);
    chk("pop_addr", imem_addr, 32'h8);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("refill_req", imem_req, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("refull_req", imem_req, 1'b0);
    chk("refull_addr", imem_addr, 32'hC);
    chk("refull_pc", instr_pc, 32'h4);

    // Redirect while the 0x8 response is outstanding
    do_reset(1'b1);
    wait_addr("reach_8", 1'b1, 32'h8);
    rv_hold = 1;
    step(1'b1, 1'b1, 1'b1, 32'h100);
    chk("wait8_req", imem_req, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid", instr_valid, 1'b0);
    chk("discard_req", imem_req, 1'b0);
    rv_hold = 0;
    wait_valid("redir_wait", 1'b0);
    chk("redir_pc", instr_pc, 32'h100);
    chk("redir_data", instr_data, 32'h113);

    // Redirect, rvalid and ready together with a non-empty buffer
    do_reset(1'b0);
    wait_addr("reach_4", 1'b0, 32'h4);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    chk("pre_valid", instr_valid, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("flush_valid", instr_valid, 1'b0);
    chk("flush_addr", imem_addr, 32'h200);
    chk("flush_req", imem_req, 1'b1);
    wait_valid("flush_wait", 1'b0);
    chk("flush_pc", instr_pc, 32'h200);

    // PC wrap at the top of the address space
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    acc_q.delete();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 20 && acc_q.size() < 2; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_count", acc_q.size() >= 2, 1'b1);
    if (acc_q.size() >= 2) begin
      chk("wrap_acc0", acc_q[0], 32'hFFFF_FFFC);
      chk("wrap_acc1", acc_q[1], 32'h0);
    end

    // Misaligned redirect target
    step(1'b1, 1'b1, 1'b1, 32'h102);
    step(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_flag", misalign, 1'b1);
    chk("mis_req", imem_req, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mis_sticky", misalign, 1'b1);
    chk("mis_halt", imem_req, 1'b0);
    do_reset(1'b1);
    chk("mis_rst", misalign, 1'b0);
`else
    chk("align_addr", imem_addr, 32'h100);
`endif

    // Reset with a request in flight; the late response must be ignored
    do_reset(1'b1);
    wait_addr("reach_0", 1'b1, 32'h0);
    rv_hold = 1;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("midrst_req", imem_req, 1'b0);
    rst_n = 1'b1;
    rv_hold = 0;
    wait_valid("late_wait", 1'b1);
    chk("late_pc", instr_pc, 32'h0);
    chk("late_data", instr_data, 32'h13);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
